meas_accbuf: RTL and testbench
==============================

MEAS_ACCBUF -- requirements
Module: meas_accbuf

Interface
REQ-001 Parameter DW, default 32: width of each accumulator word.
REQ-002 Parameter AW, default 12: buffer address width, 2^AW words, holding 2^(AW-1) x/y shot pairs.
REQ-003 Parameter OVW, default 16: overflow counter width.
REQ-004 Port clk, input, 1: the only clock, the dsp clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port reset, input, 1: reset is synchronous and active-high.
REQ-006 Port start, input, 1: one-cycle arm strobe.
REQ-007 Port trig, input, 1: one-cycle shot-period trigger from the period counter.
REQ-008 Port done, input, 1: one-cycle measurement-complete strobe from the measurement stage.
REQ-009 Port xacc, input, DW: I accumulator result, valid on the done cycle.
REQ-010 Port yacc, input, DW: Q accumulator result, valid on the done cycle.
REQ-011 Port raddr, input, AW: readout address.
REQ-012 Port rdata, output, DW: readout data.
REQ-013 Port armed, output, 1: high in the ARMED state.
REQ-014 Port running, output, 1: high in the RUN state.
REQ-015 Port full, output, 1: high in the FULL state.
REQ-016 Port wcount, output, AW+1: number of words written since the last trig in ARMED.
REQ-017 Port ovcount, output, OVW: number of dropped done pulses since the last start.

Function
REQ-018 State machine: four states, IDLE, ARMED, RUN and FULL; armed, running and full SHALL be decoded directly from the state register.
REQ-019 IDLE to ARMED on start.
REQ-020 ARMED to RUN on trig, with the write address and wcount cleared to 0 in the same cycle; a trig in any other state SHALL be ignored.
REQ-021 Capture: done in RUN SHALL capture xacc and yacc into holding registers.
REQ-022 Capture write timing: the block SHALL write x at address wa on the cycle after done, and write y at wa+1 on the following cycle.
REQ-023 Capture address update: wa SHALL advance by 2 and wcount by 2, with wcount incrementing by 1 per written word.
REQ-024 Write busy: a done arriving while the y write of the previous pair is pending is dropped and SHALL increment ovcount; the minimum accepted done spacing is 2 cycles.
REQ-025 RUN to FULL: when wcount reaches 2^AW, i.e. after the y write at address 2^AW-1, the block SHALL enter FULL and SHALL NOT wrap or write any further.
REQ-026 FULL behaviour: every done in FULL SHALL increment ovcount.
REQ-027 Done ignored: done in IDLE or ARMED SHALL be ignored and not counted.
REQ-028 Overflow arithmetic: ovcount SHALL saturate at all-ones and SHALL clear on start.
REQ-029 start in any state, including mid-pair, SHALL go to ARMED and abort any pending y write.
REQ-030 start with reset: reset SHALL win over a simultaneous start.
REQ-031 Existing buffer contents on start: SHALL be retained; wcount SHALL hold its value until the next trig.
REQ-032 start and trig in the same cycle: start SHALL win, leaving the block in ARMED; the trig SHALL NOT be taken.
REQ-033 done and trig in the same ARMED cycle: the done SHALL be ignored.
REQ-034 Readout: rdata SHALL be registered with 1-cycle latency from raddr.
REQ-035 Same-address read and write in one cycle: the read SHALL return the old data.
REQ-036 Memory implementation: single-clock simple dual-port memory, inferable as block RAM, with no reset of contents.

Reset
REQ-037 reset SHALL force the IDLE state, wa = 0, wcount = 0, ovcount = 0, clear the pending-y flag, and set armed = running = full = 0.
REQ-038 reset SHALL clear the rdata register to 0; memory contents SHALL be undefined after reset.
REQ-039 reset asserted mid-pair SHALL suppress the pending y write.

Verification
REQ-040 Basic pair capture: start, trig, then done with xacc = 0x11111111 and yacc = 0x22222222 -> mem[0] = 0x11111111, mem[1] = 0x22222222, wcount = 2; readback of raddr = 1 gives rdata = 0x22222222 one cycle later.
REQ-041 Fill to FULL (AW = 4): 8 done pulses spaced 3 cycles apart -> full = 1 after the 8th y write, wcount = 16; 3 more done pulses -> ovcount = 3 and mem[0..15] unchanged.
REQ-042 Back-to-back done: done on cycles n and n+1 -> only the first pair is written, ovcount = 1, wcount = 2.
REQ-043 Arming rules: done and trig before any start -> no writes, state IDLE, ovcount = 0; start and trig in the same cycle -> armed = 1, running = 0.
REQ-044 Re-arm mid-run: start one cycle after a done -> y not written, armed = 1, ovcount = 0; the next trig resets wcount to 0.
REQ-045 Reset mid-operation: reset asserted in RUN with a y write pending -> all outputs at reset values on the next cycle and no y write.

Source files
------------

// File: rtl/meas_accbuf.sv
// Measurement accumulator buffer: captures x/y accumulator pairs into a
// dual-port RAM after a trigger, with overflow counting and registered readout.
module meas_accbuf #(
  parameter int DW  = 32,
  parameter int AW  = 12,
  parameter int OVW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          trig,
  input  logic          done,
  input  logic [DW-1:0] xacc,
  input  logic [DW-1:0] yacc,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic          armed,
  output logic          running,
  output logic          full,
  output logic [AW:0]   wcount,
  output logic [OVW-1:0] ovcount
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_FULL} state_t;

  localparam logic [AW:0] WLAST = {1'b0, {AW{1'b1}}};

  state_t        state_q;
  logic [AW-1:0] wa_q;
  logic [AW:0]   wcount_q;
  logic [OVW-1:0] ov_q;
  logic          px_q, py_q;
  logic [DW-1:0] xh_q, yh_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] mem [2**AW];

  logic          we;
  logic [AW-1:0] wad;
  logic [DW-1:0] wdat;
  logic          last_y, accept, drop;

  // x goes out the cycle after capture, y the cycle after that; start or
  // reset kills a pending y, reset also kills a pending x.
  always_comb begin
    we   = !reset && (px_q || (py_q && !start));
    wad  = px_q ? wa_q : {wa_q[AW-1:1], 1'b1};
    wdat = px_q ? xh_q : yh_q;
  end

  // A done landing on the final y write would have nowhere to go.
  assign last_y = py_q && (wcount_q == WLAST);
  assign accept = done && (state_q == S_RUN) && !px_q && !last_y;
  assign drop   = done && (((state_q == S_RUN) && !accept) || (state_q == S_FULL));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wa_q     <= '0;
      wcount_q <= '0;
      ov_q     <= '0;
      px_q     <= 1'b0;
      py_q     <= 1'b0;
      xh_q     <= '0;
      yh_q     <= '0;
    end else begin
      if (we) wcount_q <= wcount_q + 1'b1;
      if (we && py_q) wa_q <= wa_q + AW'(2);
      if (start) begin
        state_q <= S_ARMED;
        px_q    <= 1'b0;
        py_q    <= 1'b0;
        ov_q    <= '0;
      end else begin
        px_q <= 1'b0;
        py_q <= px_q;
        case (state_q)
          S_ARMED: if (trig) begin
            state_q  <= S_RUN;
            wa_q     <= '0;
            wcount_q <= '0;
          end
          S_RUN: begin
            if (last_y) state_q <= S_FULL;
            if (accept) begin
              xh_q <= xacc;
              yh_q <= yacc;
              px_q <= 1'b1;
            end
          end
          default: ;
        endcase
        if (drop && (ov_q != '1)) ov_q <= ov_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wad] <= wdat;
  end

  // Read-before-write: same-address collisions return the old word.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem[raddr];
  end

  assign rdata   = rdata_q;
  assign armed   = (state_q == S_ARMED);
  assign running = (state_q == S_RUN);
  assign full    = (state_q == S_FULL);
  assign wcount  = wcount_q;
  assign ovcount = ov_q;

endmodule

// File: tb/tb_meas_accbuf.sv
// Self-checking bench for meas_accbuf with a 16-word buffer and 4-bit
// overflow counter so fill and saturation are reachable quickly.
module tb_meas_accbuf;
  localparam int DW = 32, AW = 4, OVW = 4;

  logic          clk = 1'b0;
  logic          reset, start, trig, done;
  logic [DW-1:0] xacc, yacc;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          armed, running, full;
  logic [AW:0]   wcount;
  logic [OVW-1:0] ovcount;

  meas_accbuf #(.DW(DW), .AW(AW), .OVW(OVW)) dut (
    .clk(clk), .reset(reset), .start(start), .trig(trig), .done(done),
    .xacc(xacc), .yacc(yacc), .raddr(raddr), .rdata(rdata),
    .armed(armed), .running(running), .full(full),
    .wcount(wcount), .ovcount(ovcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } pair_t;

  pair_t         tbl [8];
  logic [DW-1:0] sb [$];
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string nm, input logic a, input logic r, input logic f);
    chk({nm, ".armed"}, 64'(armed), 64'(a));
    chk({nm, ".running"}, 64'(running), 64'(r));
    chk({nm, ".full"}, 64'(full), 64'(f));
  endtask

  task automatic give_done(input logic [DW-1:0] x, input logic [DW-1:0] y);
    xacc = x; yacc = y; done = 1'b1;
    cyc();
    done = 1'b0;
  endtask

  // Expected word is queued when the address is driven, compared when rdata appears.
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] e;
    raddr = a;
    sb.push_back(exp);
    cyc();
    e = sb.pop_front();
    chk($sformatf("rdata[%0d]", a), 64'(rdata), 64'(e));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i].x = 32'hA5000000 + 32'(i * 16'h0101);
      tbl[i].y = 32'h5A000000 + 32'(i * 16'h1010) + 32'h7;
    end
    reset = 1'b1; start = 1'b0; trig = 1'b0; done = 1'b0;
    xacc = '0; yacc = '0; raddr = '0;
    cyc(); cyc();
    st("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.wcount", 64'(wcount), 64'd0);
    chk("reset.ovcount", 64'(ovcount), 64'd0);
    chk("reset.rdata", 64'(rdata), 64'd0);
    reset = 1'b0;

    // done + trig before any start: nothing happens
    trig = 1'b1;
    give_done(32'hDEAD0001, 32'hDEAD0002);
    trig = 1'b0;
    cyc(); cyc();
    st("idle_ignore", 1'b0, 1'b0, 1'b0);
    chk("idle_ignore.ovcount", 64'(ovcount), 64'd0);
    chk("idle_ignore.wcount", 64'(wcount), 64'd0);

    // start and trig together: start wins
    start = 1'b1; trig = 1'b1;
    cyc();
    start = 1'b0; trig = 1'b0;
    st("start_trig", 1'b1, 1'b0, 1'b0);
    // done with trig in ARMED is ignored
    trig = 1'b1;
    give_done(32'hBAD0BAD0, 32'hBAD1BAD1);
    trig = 1'b0;
    st("trig_run", 1'b0, 1'b1, 1'b0);
    chk("trig_run.wcount", 64'(wcount), 64'd0);
    chk("trig_run.ovcount", 64'(ovcount), 64'd0);

    // basic pair capture
    give_done(32'h11111111, 32'h22222222);
    cyc();
    chk("basic.wcount_x", 64'(wcount), 64'd1);
    cyc();
    chk("basic.wcount_y", 64'(wcount), 64'd2);
    rd(0, 32'h11111111);
    rd(1, 32'h22222222);

    // back-to-back done after re-arm
    start = 1'b1; cyc(); start = 1'b0;
    trig = 1'b1; cyc(); trig = 1'b0;
    xacc = 32'hA0A0A0A0; yacc = 32'hA1A1A1A1; done = 1'b1;
    cyc();
    xacc = 32'hB0B0B0B0; yacc = 32'hB1B1B1B1;
    cyc();
    done = 1'b0;
    cyc(); cyc();
    chk("b2b.wcount", 64'(wcount), 64'd2);
    chk("b2b.ovcount", 64'(ovcount), 64'd1);
    rd(0, 32'hA0A0A0A0);
    rd(1, 32'hA1A1A1A1);

    // re-arm one cycle after done: y aborted
    start = 1'b1; cyc(); start = 1'b0;
    trig = 1'b1; cyc(); trig = 1'b0;
    give_done(32'hC0C0C0C0, 32'hC1C1C1C1);
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    st("rearm", 1'b1, 1'b0, 1'b0);
    chk("rearm.ovcount", 64'(ovcount), 64'd0);
    rd(0, 32'hC0C0C0C0);
    rd(1, 32'hA1A1A1A1);
    trig = 1'b1; cyc(); trig = 1'b0;
    chk("rearm.trig_wcount", 64'(wcount), 64'd0);

    // fill to FULL with done spaced 3 cycles
    for (int i = 0; i < 8; i++) begin
      give_done(tbl[i].x, tbl[i].y);
      cyc(); cyc();
      chk($sformatf("fill%0d.wcount", i), 64'(wcount), 64'(2 * (i + 1)));
      chk($sformatf("fill%0d.full", i), 64'(full), 64'(i == 7));
    end
    for (int i = 0; i < 3; i++) begin
      give_done(32'hEEEE0000 + 32'(i), 32'hFFFF0000 + 32'(i));
      cyc();
    end
    chk("full.ovcount", 64'(ovcount), 64'd3);
    trig = 1'b1; cyc(); trig = 1'b0;
    st("full_trig", 1'b0, 1'b0, 1'b1);
    chk("full.wcount", 64'(wcount), 64'd16);
    for (int a = 0; a < 16; a++)
      rd(AW'(a), (a % 2 == 0) ? tbl[a / 2].x : tbl[a / 2].y);
    for (int i = 0; i < 14; i++) begin
      give_done(32'h1, 32'h2);
      cyc();
    end
    chk("sat.ovcount", 64'(ovcount), 64'd15);

    // start from FULL: ovcount clears, wcount holds until trig
    start = 1'b1; cyc(); start = 1'b0;
    st("full_start", 1'b1, 1'b0, 1'b0);
    chk("full_start.ovcount", 64'(ovcount), 64'd0);
    chk("full_start.wcount", 64'(wcount), 64'd16);

    // reset with y write pending
    trig = 1'b1; cyc(); trig = 1'b0;
    give_done(32'hD0D0D0D0, 32'hD1D1D1D1);
    cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    st("midreset", 1'b0, 1'b0, 1'b0);
    chk("midreset.wcount", 64'(wcount), 64'd0);
    chk("midreset.ovcount", 64'(ovcount), 64'd0);
    chk("midreset.rdata", 64'(rdata), 64'd0);
    rd(1, tbl[0].y);
    rd(0, 32'hD0D0D0D0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
